// File: rtl/regfile_port_arbiter.sv
// Arbitrates the register file read ports and debug write path between decode and the debug bridge.
// Build option REGARB_DBG_WRITE_EN enables debug writes; without it debug writes are rejected with DBG_ERR.
module regfile_port_arbiter #(
    parameter int MAX_CORE_BURST = 4,
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32
) (
    input  logic              RST,
    input  logic              CLK_DC,
    input  logic              CORE_REQ,
    input  logic [ADDR_W-1:0] CORE_A1,
    input  logic [ADDR_W-1:0] CORE_A2,
    output logic              CORE_GNT,
    input  logic              DBG_REQ,
    input  logic              DBG_WE,
    input  logic [ADDR_W-1:0] DBG_ADDR,
    input  logic [DATA_W-1:0] DBG_WDATA,
    output logic              DBG_ACK,
    output logic [DATA_W-1:0] DBG_RDATA,
    output logic              DBG_ERR,
    output logic [ADDR_W-1:0] RF_A1,
    output logic [ADDR_W-1:0] RF_A2,
    input  logic [DATA_W-1:0] RF_RD1,
    output logic              RF_DWE,
    output logic [ADDR_W-1:0] RF_DA3,
    output logic [DATA_W-1:0] RF_DWB
);

    if (MAX_CORE_BURST < 1 || MAX_CORE_BURST > 15) begin : g_bad_burst
        $error("regfile_port_arbiter: MAX_CORE_BURST must be within 1..15");
    end

    localparam logic [3:0] BURST_LIM = 4'(MAX_CORE_BURST);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_RDD, S_WR} state_t;

    state_t              state;
    logic [3:0]          starv_cnt;
    logic [ADDR_W-1:0]   a1_q;
    logic [ADDR_W-1:0]   a2_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ack_q;
    logic                err_q;
    logic                core_win;
    logic                take_wr;

    // Core wins unless the debug side has waited out a full burst.
    assign core_win = CORE_REQ && ((starv_cnt < BURST_LIM) || !DBG_REQ);
    assign take_wr  = (state == S_IDLE) && !core_win && DBG_REQ && DBG_WE;

    always_comb begin
        CORE_GNT = RST && (state == S_IDLE) && core_win;
        RF_A1    = a1_q;
        RF_A2    = a2_q;
        if (CORE_GNT) begin
            RF_A1 = CORE_A1;
            RF_A2 = CORE_A2;
        end else if (state == S_RD) begin
            RF_A1 = DBG_ADDR;
        end
    end

    // Read data comes straight from the register file during the ack cycle, then is held.
    assign DBG_RDATA = (state == S_RDD) ? RF_RD1 : rdata_q;
    assign DBG_ACK   = ack_q;
    assign DBG_ERR   = err_q;

    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            starv_cnt <= 4'd0;
            a1_q      <= '0;
            a2_q      <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            a1_q  <= RF_A1;
            a2_q  <= RF_A2;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (core_win) begin
                        if (DBG_REQ && (starv_cnt < BURST_LIM))
                            starv_cnt <= starv_cnt + 4'd1;
                    end else if (DBG_REQ) begin
                        if (DBG_WE) begin
                            state <= S_WR;
                            ack_q <= 1'b1;
`ifdef REGARB_DBG_WRITE_EN
                            err_q <= 1'b0;
`else
                            err_q <= 1'b1;
`endif
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    state <= S_RDD;
                    ack_q <= 1'b1;
                end
                S_RDD: begin
                    state     <= S_IDLE;
                    rdata_q   <= RF_RD1;
                    starv_cnt <= 4'd0;
                end
                S_WR: begin
                    state     <= S_IDLE;
                    starv_cnt <= 4'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef REGARB_DBG_WRITE_EN
    logic              dwe_q;
    logic [ADDR_W-1:0] da3_q;
    logic [DATA_W-1:0] dwb_q;

    // x0 is hardwired: the write is acknowledged but the strobe is suppressed.
    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            dwe_q <= 1'b0;
            da3_q <= '0;
            dwb_q <= '0;
        end else begin
            dwe_q <= take_wr && (DBG_ADDR != '0);
            if (take_wr) begin
                da3_q <= DBG_ADDR;
                dwb_q <= DBG_WDATA;
            end
        end
    end

    assign RF_DWE = dwe_q;
    assign RF_DA3 = da3_q;
    assign RF_DWB = dwb_q;
`else
    logic unused_wdata;
    assign unused_wdata = (^DBG_WDATA) ^ take_wr;
    assign RF_DWE = 1'b0;
    assign RF_DA3 = '0;
    assign RF_DWB = '0;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: cycle table with hand-derived outputs plus a read-data scoreboard.
`timescale 1ns/100ps
module tb_regfile_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGARB_DBG_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic          RST, CLK_DC, CORE_REQ, CORE_GNT, DBG_REQ, DBG_WE, DBG_ACK, DBG_ERR, RF_DWE;
    logic [AW-1:0] CORE_A1, CORE_A2, DBG_ADDR, RF_A1, RF_A2, RF_DA3;
    logic [DW-1:0] DBG_WDATA, DBG_RDATA, RF_RD1, RF_DWB;

    regfile_port_arbiter #(.MAX_CORE_BURST(4), .ADDR_W(AW), .DATA_W(DW)) dut (
        .RST(RST), .CLK_DC(CLK_DC), .CORE_REQ(CORE_REQ), .CORE_A1(CORE_A1), .CORE_A2(CORE_A2),
        .CORE_GNT(CORE_GNT), .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR),
        .DBG_WDATA(DBG_WDATA), .DBG_ACK(DBG_ACK), .DBG_RDATA(DBG_RDATA), .DBG_ERR(DBG_ERR),
        .RF_A1(RF_A1), .RF_A2(RF_A2), .RF_RD1(RF_RD1), .RF_DWE(RF_DWE), .RF_DA3(RF_DA3),
        .RF_DWB(RF_DWB)
    );

    initial CLK_DC = 1'b0;
    always #5 CLK_DC = ~CLK_DC;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 0) return 32'h0;
        if (i == 5) return 32'hDEADBEEF;
        if (i == 9) return 32'h0000_0909;
        return 32'hA000_0000 | 32'(i);
    endfunction

    // Register file environment: read data registered on CLK_DC, debug write port.
    logic          rf_load;
    logic [DW-1:0] regs [32];
    always @(posedge CLK_DC) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
        end else if (RF_DWE) begin
            regs[RF_DA3] <= RF_DWB;
        end
        RF_RD1 <= regs[RF_A1];
    end

    typedef struct {
        logic          creq, dreq, dwe, issue;
        logic [AW-1:0] ca1, ca2, daddr;
        logic [DW-1:0] wd;
        logic          gnt, ack, err, dwo;
        logic [AW-1:0] a1, a2;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_mem [32];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic creq, input logic [AW-1:0] ca1, input logic [AW-1:0] ca2,
                       input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                       input logic [DW-1:0] wd, input logic issue,
                       input logic gnt, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic ack, input logic err, input logic dwo);
        vec_t v;
        v.creq = creq; v.ca1 = ca1; v.ca2 = ca2; v.dreq = dreq; v.dwe = dwe; v.daddr = daddr;
        v.wd = wd; v.issue = issue; v.gnt = gnt; v.a1 = a1; v.a2 = a2; v.ack = ack; v.err = err;
        v.dwo = dwo;
        vecs.push_back(v);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'(CORE_GNT), 32'h0);
        chk({tag, "_a1"}, 32'(RF_A1), 32'h0);
        chk({tag, "_a2"}, 32'(RF_A2), 32'h0);
        chk({tag, "_ack"}, 32'(DBG_ACK), 32'h0);
        chk({tag, "_err"}, 32'(DBG_ERR), 32'h0);
        chk({tag, "_rdata"}, DBG_RDATA, 32'h0);
        chk({tag, "_dwe"}, 32'(RF_DWE), 32'h0);
        chk({tag, "_da3"}, 32'(RF_DA3), 32'h0);
        chk({tag, "_dwb"}, RF_DWB, 32'h0);
    endtask

    // Every read ack retires the oldest expected read value.
    always @(negedge CLK_DC) begin
        if (RST && DBG_ACK && !DBG_WE) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_sb: ack with no pending read, rdata %h required none", DBG_RDATA);
            end else begin
                chk("rdata", DBG_RDATA, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) exp_mem[i] = init_val(i);
        RST = 1'b0; rf_load = 1'b1;
        CORE_REQ = 0; CORE_A1 = 0; CORE_A2 = 0;
        DBG_REQ = 0; DBG_WE = 0; DBG_ADDR = 0; DBG_WDATA = 0;

        // core only, 10 cycles
        for (int i = 0; i < 10; i++) add(1, 3, 7, 0, 0, 0, 0, 0,  1, 3, 7, 0, 0, 0);
        add(0, 3, 7, 0, 0, 0, 0, 0,                               0, 3, 7, 0, 0, 0);
        // starvation: debug read of x5 under continuous core traffic
        add(1, 1, 2, 1, 0, 5, 0, 1,                               1, 1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 2, 1, 0, 5, 0, 0,   1, 1, 2, 0, 0, 0);
        add(1, 1, 2, 1, 0, 5, 0, 0,                               0, 1, 2, 0, 0, 0);
        add(1, 1, 2, 1, 0, 5, 0, 0,                               0, 5, 2, 0, 0, 0);
        add(1, 1, 2, 1, 0, 5, 0, 0,                               0, 5, 2, 1, 0, 0);
        add(1, 1, 2, 0, 0, 0, 0, 0,                               1, 1, 2, 0, 0, 0);
        // debug write x9 then read back
        add(0, 1, 2, 1, 1, 9, 32'h12345678, 1,                    0, 1, 2, 0, 0, 0);
        add(0, 1, 2, 1, 1, 9, 32'h12345678, 0,                    0, 1, 2, 1, !WR_EN, WR_EN);
        add(0, 1, 2, 1, 0, 9, 0, 1,                               0, 1, 2, 0, 0, 0);
        add(0, 1, 2, 1, 0, 9, 0, 0,                               0, 9, 2, 0, 0, 0);
        add(0, 1, 2, 1, 0, 9, 0, 0,                               0, 9, 2, 1, 0, 0);
        add(0, 1, 2, 0, 0, 0, 0, 0,                               0, 9, 2, 0, 0, 0);
        // write to x0 is swallowed, then read x0
        add(0, 1, 2, 1, 1, 0, 32'hFFFFFFFF, 1,                    0, 9, 2, 0, 0, 0);
        add(0, 1, 2, 1, 1, 0, 32'hFFFFFFFF, 0,                    0, 9, 2, 1, !WR_EN, 0);
        add(0, 1, 2, 1, 0, 0, 0, 1,                               0, 9, 2, 0, 0, 0);
        add(0, 1, 2, 1, 0, 0, 0, 0,                               0, 0, 2, 0, 0, 0);
        add(0, 1, 2, 1, 0, 0, 0, 0,                               0, 0, 2, 1, 0, 0);
        add(0, 1, 2, 0, 0, 0, 0, 0,                               0, 0, 2, 0, 0, 0);
        // debug is non-preemptive: core request during the read gets no grant
        add(0, 8, 10, 1, 0, 5, 0, 1,                              0, 0, 2, 0, 0, 0);
        add(1, 8, 10, 1, 0, 5, 0, 0,                              0, 5, 2, 0, 0, 0);
        add(1, 8, 10, 1, 0, 5, 0, 0,                              0, 5, 2, 1, 0, 0);
        add(1, 8, 10, 0, 0, 0, 0, 0,                              1, 8, 10, 0, 0, 0);
        // counter restarted after the ack: a fresh full burst before debug wins again
        add(1, 8, 10, 1, 0, 9, 0, 1,                              1, 8, 10, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 8, 10, 1, 0, 9, 0, 0,  1, 8, 10, 0, 0, 0);
        add(1, 8, 10, 1, 0, 9, 0, 0,                              0, 8, 10, 0, 0, 0);
        add(1, 8, 10, 1, 0, 9, 0, 0,                              0, 9, 10, 0, 0, 0);
        add(1, 8, 10, 1, 0, 9, 0, 0,                              0, 9, 10, 1, 0, 0);
        add(1, 8, 10, 0, 0, 0, 0, 0,                              1, 8, 10, 0, 0, 0);

        repeat (2) @(posedge CLK_DC);
        @(negedge CLK_DC);
        #1 chk_zero("reset");
        #1 RST = 1'b1;
        rf_load = 1'b0;

        foreach (vecs[k]) begin
            @(posedge CLK_DC);
            #1;
            CORE_REQ = vecs[k].creq; CORE_A1 = vecs[k].ca1; CORE_A2 = vecs[k].ca2;
            DBG_REQ = vecs[k].dreq; DBG_WE = vecs[k].dwe; DBG_ADDR = vecs[k].daddr;
            DBG_WDATA = vecs[k].wd;
            if (vecs[k].issue && !vecs[k].dwe) sb_q.push_back(exp_mem[vecs[k].daddr]);
            if (vecs[k].issue && vecs[k].dwe && WR_EN && vecs[k].daddr != 0)
                exp_mem[vecs[k].daddr] = vecs[k].wd;
            @(negedge CLK_DC);
            chk($sformatf("gnt[%0d]", k), 32'(CORE_GNT), 32'(vecs[k].gnt));
            chk($sformatf("a1[%0d]", k), 32'(RF_A1), 32'(vecs[k].a1));
            chk($sformatf("a2[%0d]", k), 32'(RF_A2), 32'(vecs[k].a2));
            chk($sformatf("ack[%0d]", k), 32'(DBG_ACK), 32'(vecs[k].ack));
            chk($sformatf("err[%0d]", k), 32'(DBG_ERR), 32'(vecs[k].err));
            chk($sformatf("dwe[%0d]", k), 32'(RF_DWE), 32'(vecs[k].dwo));
            if (vecs[k].dwo) begin
                chk($sformatf("da3[%0d]", k), 32'(RF_DA3), 32'(vecs[k].daddr));
                chk($sformatf("dwb[%0d]", k), RF_DWB, vecs[k].wd);
            end
        end

        // reset asserted while a debug read is in flight
        @(posedge CLK_DC);
        #1 CORE_REQ = 0; DBG_REQ = 1; DBG_WE = 0; DBG_ADDR = 5;
        @(negedge CLK_DC);
        chk("mid_idle_gnt", 32'(CORE_GNT), 32'h0);
        @(negedge CLK_DC);
        chk("mid_rd_a1", 32'(RF_A1), 32'd5);
        #1 RST = 1'b0;
        #1 chk_zero("midrst");
        #1 DBG_REQ = 0; CORE_REQ = 1; CORE_A1 = 4; CORE_A2 = 6; RST = 1'b1;
        #1;
        chk("post_rst_gnt", 32'(CORE_GNT), 32'h1);
        chk("post_rst_a1", 32'(RF_A1), 32'd4);
        chk("post_rst_a2", 32'(RF_A2), 32'd6);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_DC);
            chk($sformatf("aborted_ack[%0d]", i), 32'(DBG_ACK), 32'h0);
            chk($sformatf("post_rst_gnt[%0d]", i), 32'(CORE_GNT), 32'h1);
        end

        chk("sb_pending", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
